// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and the registered E-stage control bundle for the ID/EX stage.
package id_ex_stage_pkg;

  // ALU operation encodings; must stay in step with the ALU decoder.
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLL   = 3'b101,
    ALU_PASSB = 3'b111
  } alu_op_e;

  // Operand forwarding selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Writeback result selects.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Control bits carried through the ID/EX register.
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic       jump;
    logic       alusrc;
  } ctrl_e_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Forwarding select for one source operand; MEM beats WB, x0 never forwarded.
module forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rdm,
  input  logic                      regwritem,
  input  logic [REG_ADDR_WIDTH-1:0] rdw,
  input  logic                      regwritew,
  output logic [1:0]                fwd
);

  // Pick the youngest in-flight producer of rs.
  always_comb begin
    fwd = FWD_RF;
    if (regwritem && (rdm != '0) && (rdm == rs)) begin
      fwd = FWD_MEM;
    end else if (regwritew && (rdw != '0) && (rdw == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and SrcB selection for the ALU.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROL_WIDTH  = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ValidD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [CONTROL_WIDTH-1:0]  ALUControlD,
  input  logic                      ALUSrcD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic                      BranchD,
  input  logic                      JumpD,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [CONTROL_WIDTH-1:0]  ALUControlE,
  output logic [DATA_WIDTH-1:0]     WriteDataE,
  output logic [DATA_WIDTH-1:0]     PCTargetE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ValidE,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      BranchE,
  output logic                      JumpE,
  output logic [1:0]                ResultSrcE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE
);

  ctrl_e_t                   ctrl_e;
  logic [CONTROL_WIDTH-1:0]  alucontrol_e;
  logic [DATA_WIDTH-1:0]     rd1_e;
  logic [DATA_WIDTH-1:0]     rd2_e;
  logic [DATA_WIDTH-1:0]     immext_e;
  logic [DATA_WIDTH-1:0]     pc_e;
  logic [REG_ADDR_WIDTH-1:0] rs1_e;
  logic [REG_ADDR_WIDTH-1:0] rs2_e;
  logic [REG_ADDR_WIDTH-1:0] rd_e;

  // Pipeline register: reset/flush bubble, then stall hold, then capture.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ctrl_e       <= '0;
      alucontrol_e <= '0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      immext_e     <= '0;
      pc_e         <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
    end else if (!StallE) begin
      ctrl_e.valid     <= ValidD;
      ctrl_e.regwrite  <= RegWriteD;
      ctrl_e.memwrite  <= MemWriteD;
      ctrl_e.resultsrc <= ResultSrcD;
      ctrl_e.branch    <= BranchD;
      ctrl_e.jump      <= JumpD;
      ctrl_e.alusrc    <= ALUSrcD;
      alucontrol_e     <= ALUControlD;
      rd1_e            <= RD1D;
      rd2_e            <= RD2D;
      immext_e         <= ImmExtD;
      pc_e             <= PCD;
      rs1_e            <= Rs1D;
      rs2_e            <= Rs2D;
      rd_e             <= RdD;
    end
  end

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs        (rs1_e),
    .rdm       (RdM),
    .regwritem (RegWriteM),
    .rdw       (RdW),
    .regwritew (RegWriteW),
    .fwd       (ForwardAE)
  );

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs        (rs2_e),
    .rdm       (RdM),
    .regwritem (RegWriteM),
    .rdw       (RdW),
    .regwritew (RegWriteW),
    .fwd       (ForwardBE)
  );

  // Operand muxes: forwarded rs1/rs2, then immediate-or-register for SrcB.
  always_comb begin
    case (ForwardAE)
      FWD_MEM: SrcA = ALUResultM;
      FWD_WB:  SrcA = ResultW;
      default: SrcA = rd1_e;
    endcase
    case (ForwardBE)
      FWD_MEM: WriteDataE = ALUResultM;
      FWD_WB:  WriteDataE = ResultW;
      default: WriteDataE = rd2_e;
    endcase
    SrcB = ctrl_e.alusrc ? immext_e : WriteDataE;
  end

  // Branch/jump target wraps modulo 2^DATA_WIDTH.
  assign PCTargetE = pc_e + immext_e;

  assign ALUControlE = alucontrol_e;
  assign Rs1E        = rs1_e;
  assign Rs2E        = rs2_e;
  assign RdE         = rd_e;
  assign ValidE      = ctrl_e.valid;
  assign ResultSrcE  = ctrl_e.resultsrc;

  // Side-effecting controls only act for a real instruction.
  assign RegWriteE = ctrl_e.regwrite & ctrl_e.valid;
  assign MemWriteE = ctrl_e.memwrite & ctrl_e.valid;
  assign BranchE   = ctrl_e.branch   & ctrl_e.valid;
  assign JumpE     = ctrl_e.jump     & ctrl_e.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]  ResultSrcD;
  logic        StallE, FlushE;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [31:0] ALUResultM, ResultW;
  logic [31:0] SrcA, SrcB, WriteDataE, PCTargetE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE, RegWriteE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_WIDTH     (32),
    .CONTROL_WIDTH  (3),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ValidD      (ValidD),
    .RD1D        (RD1D),
    .RD2D        (RD2D),
    .ImmExtD     (ImmExtD),
    .PCD         (PCD),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RdD         (RdD),
    .ALUControlD (ALUControlD),
    .ALUSrcD     (ALUSrcD),
    .RegWriteD   (RegWriteD),
    .MemWriteD   (MemWriteD),
    .ResultSrcD  (ResultSrcD),
    .BranchD     (BranchD),
    .JumpD       (JumpD),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .RdM         (RdM),
    .RegWriteM   (RegWriteM),
    .ALUResultM  (ALUResultM),
    .RdW         (RdW),
    .RegWriteW   (RegWriteW),
    .ResultW     (ResultW),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .ALUControlE (ALUControlE),
    .WriteDataE  (WriteDataE),
    .PCTargetE   (PCTargetE),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .ValidE      (ValidE),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .ResultSrcE  (ResultSrcE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are settled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    ValidD = 1'b1; RD1D = 32'h11; RD2D = 32'h22; ImmExtD = 32'h33; PCD = 32'h100;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; ALUControlD = 3'b001; ALUSrcD = 1'b0;
    RegWriteD = 1'b1; MemWriteD = 1'b0; ResultSrcD = 2'b01; BranchD = 1'b0; JumpD = 1'b1;
    RdM = 5'd0; RegWriteM = 1'b0; ALUResultM = 32'h0; RdW = 5'd0; RegWriteW = 1'b0; ResultW = 32'h0;

    // Reset held two cycles with live D inputs.
    step(); step();
    chk("rst_ValidE",    32'(ValidE),    32'd0);
    chk("rst_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("rst_JumpE",     32'(JumpE),     32'd0);
    chk("rst_SrcA",      SrcA,           32'd0);
    chk("rst_SrcB",      SrcB,           32'd0);
    chk("rst_PCTarget",  PCTargetE,      32'd0);
    chk("rst_RdE",       32'(RdE),       32'd0);

    // First capture after release.
    rst = 1'b0;
    step();
    chk("cap_ValidE",     32'(ValidE),      32'd1);
    chk("cap_SrcA",       SrcA,             32'h11);
    chk("cap_SrcB",       SrcB,             32'h22);
    chk("cap_WriteData",  WriteDataE,       32'h22);
    chk("cap_PCTarget",   PCTargetE,        32'h133);
    chk("cap_RegWriteE",  32'(RegWriteE),   32'd1);
    chk("cap_JumpE",      32'(JumpE),       32'd1);
    chk("cap_ResultSrcE", 32'(ResultSrcE),  32'd1);
    chk("cap_ALUCtlE",    32'(ALUControlE), 32'd1);
    chk("cap_RdE",        32'(RdE),         32'd3);
    chk("cap_Rs1E",       32'(Rs1E),        32'd1);

    // MEM/WB forwarding to rs1, MEM priority.
    Rs1D = 5'd5; RD1D = 32'hAAAA; Rs2D = 5'd6; RD2D = 32'hBB; JumpD = 1'b0;
    step();
    chk("fwd_none_SrcA", SrcA, 32'hAAAA);
    RdM = 5'd5; RegWriteM = 1'b1; ALUResultM = 32'h10;
    #1;
    chk("fwd_mem_FwdA", 32'(ForwardAE), 32'd2);
    chk("fwd_mem_SrcA", SrcA,           32'h10);
    RdW = 5'd5; RegWriteW = 1'b1; ResultW = 32'h20;
    #1;
    chk("fwd_prio_SrcA", SrcA,           32'h10);
    chk("fwd_prio_FwdB", 32'(ForwardBE), 32'd0);
    chk("fwd_prio_SrcB", SrcB,           32'hBB);
    RegWriteM = 1'b0;
    #1;
    chk("fwd_wb_FwdA", 32'(ForwardAE), 32'd1);
    chk("fwd_wb_SrcA", SrcA,           32'h20);
    RegWriteW = 1'b0;

    // x0 is never forwarded.
    Rs2D = 5'd0; RD2D = 32'h0; ALUSrcD = 1'b0;
    step();
    RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'hDEAD;
    RdW = 5'd0; RegWriteW = 1'b1; ResultW = 32'hBEEF;
    #1;
    chk("x0_FwdB", 32'(ForwardBE), 32'd0);
    chk("x0_SrcB", SrcB,           32'd0);
    RegWriteM = 1'b0; RegWriteW = 1'b0;

    // Immediate SrcB and PC target, including wrap.
    ALUSrcD = 1'b1; ImmExtD = 32'hFFFF_FFFC; PCD = 32'h2; Rs2D = 5'd7; RD2D = 32'h77;
    step();
    chk("imm_SrcB",      SrcB,       32'hFFFF_FFFC);
    chk("imm_WriteData", WriteDataE, 32'h77);
    chk("imm_PCTarget",  PCTargetE,  32'hFFFF_FFFE);
    PCD = 32'h8; ImmExtD = 32'hFFFF_FFF8;
    step();
    chk("wrap_PCTarget", PCTargetE, 32'h0);

    // Stall holds the register while D changes; forwarding still tracks M.
    ValidD = 1'b1; RdD = 5'd9; RD1D = 32'h1234; Rs1D = 5'd10; ALUSrcD = 1'b0;
    RD2D = 32'h55; Rs2D = 5'd11; PCD = 32'h40; ImmExtD = 32'h4;
    RegWriteD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1; JumpD = 1'b0; ALUControlD = 3'b100;
    step();
    chk("pre_RdE",      32'(RdE),       32'd9);
    chk("pre_MemWrite", 32'(MemWriteE), 32'd1);
    chk("pre_BranchE",  32'(BranchE),   32'd1);
    StallE = 1'b1;
    RdD = 5'd12; RD1D = 32'hFFFF; Rs1D = 5'd13; PCD = 32'h80; ALUControlD = 3'b010; MemWriteD = 1'b0;
    step(); step(); step();
    chk("stall_RdE",      32'(RdE),         32'd9);
    chk("stall_SrcA",     SrcA,             32'h1234);
    chk("stall_PCTarget", PCTargetE,        32'h44);
    chk("stall_ALUCtlE",  32'(ALUControlE), 32'd4);
    chk("stall_MemWrite", 32'(MemWriteE),   32'd1);
    RdM = 5'd10; RegWriteM = 1'b1; ALUResultM = 32'h999;
    #1;
    chk("stall_fwd_SrcA", SrcA, 32'h999);
    RegWriteM = 1'b0;

    // Flush beats stall.
    FlushE = 1'b1;
    step();
    chk("flush_ValidE",    32'(ValidE),    32'd0);
    chk("flush_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("flush_MemWriteE", 32'(MemWriteE), 32'd0);
    chk("flush_BranchE",   32'(BranchE),   32'd0);
    chk("flush_RdE",       32'(RdE),       32'd0);
    chk("flush_SrcA",      SrcA,           32'd0);
    chk("flush_PCTarget",  PCTargetE,      32'd0);
    FlushE = 1'b0; StallE = 1'b0;

    // Invalid slot: captured but no side effects.
    ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1; JumpD = 1'b1; RdD = 5'd14;
    step();
    chk("inv_RdE",       32'(RdE),       32'd14);
    chk("inv_ValidE",    32'(ValidE),    32'd0);
    chk("inv_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("inv_MemWriteE", 32'(MemWriteE), 32'd0);
    chk("inv_BranchE",   32'(BranchE),   32'd0);
    chk("inv_JumpE",     32'(JumpE),     32'd0);
    ValidD = 1'b1;
    step();
    chk("val_RegWriteE", 32'(RegWriteE), 32'd1);
    chk("val_JumpE",     32'(JumpE),     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-stage operand logic for the pipelined core; sits directly upstream of the ALU.
- Registers decode outputs each cycle, resolves RAW hazards by forwarding from the MEM and WB stages, and selects immediate vs register for SrcB.
- Drives SrcA, SrcB and ALUControl into the ALU. Also drives WriteDataE, PCTargetE and the registered control bundle to the downstream stages.

Parameters:
DATA_WIDTH, 32, datapath width
CONTROL_WIDTH, 3, ALUControl width; must match the ALU encoding
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ValidD  input  1  decode slot holds a real instruction
RD1D  input  DATA_WIDTH  register file read data 1
RD2D  input  DATA_WIDTH  register file read data 2
ImmExtD  input  DATA_WIDTH  sign-extended immediate
PCD  input  DATA_WIDTH  instruction PC
Rs1D  input  REG_ADDR_WIDTH  source register 1 index
Rs2D  input  REG_ADDR_WIDTH  source register 2 index
RdD  input  REG_ADDR_WIDTH  destination register index
ALUControlD  input  CONTROL_WIDTH  ALU operation
ALUSrcD  input  1  1 = SrcB takes immediate
RegWriteD  input  1  writes rd
MemWriteD  input  1  store
ResultSrcD  input  2  writeback select
BranchD  input  1  conditional branch
JumpD  input  1  jump
StallE  input  1  hold the EX register
FlushE  input  1  insert a bubble
RdM  input  REG_ADDR_WIDTH  MEM-stage destination
RegWriteM  input  1  MEM-stage writes rd
ALUResultM  input  DATA_WIDTH  MEM-stage forwarding value
RdW  input  REG_ADDR_WIDTH  WB-stage destination
RegWriteW  input  1  WB-stage writes rd
ResultW  input  DATA_WIDTH  WB-stage forwarding value
SrcA  output  DATA_WIDTH  ALU operand A
SrcB  output  DATA_WIDTH  ALU operand B
ALUControlE  output  CONTROL_WIDTH  ALU operation
WriteDataE  output  DATA_WIDTH  forwarded rs2, used as store data
PCTargetE  output  DATA_WIDTH  PCE + ImmExtE
Rs1E, Rs2E, RdE  output  REG_ADDR_WIDTH  registered indices for the hazard unit
ValidE, RegWriteE, MemWriteE, BranchE, JumpE  output  1  registered control
ResultSrcE  output  2  registered writeback select
ForwardAE, ForwardBE  output  2  forwarding select: 00 = RF, 10 = MEM, 01 = WB

Behaviour:
Register update on rising clk, in priority order:
- rst: ValidE and all control bits 0, all data/index registers 0.
- else FlushE: same as reset (bubble). FlushE wins over StallE.
- else StallE: hold all registers.
- else capture all D-side inputs.
- Reset and flush abort any in-flight instruction in the same cycle; there is no partial state.

Control gating:
- RegWriteE, MemWriteE, BranchE and JumpE are the registered value AND ValidE.
- A captured instruction with ValidD=0 therefore has no side effects.

Forwarding (combinational, evaluated every cycle):
- ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
- Otherwise 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
- Otherwise 00.
- MEM has priority over WB. x0 is never forwarded. ForwardBE is the same rule using Rs2E.

Operand selection:
- SrcA = forwarded rs1.
- WriteDataE = forwarded rs2.
- SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALUControlE passes straight through from its register.

Arithmetic:
- PCTargetE = PCE + ImmExtE, modulo 2^DATA_WIDTH, wrap silently.

Latency:
- D inputs appear at the E outputs 1 cycle later.
- Forwarded values reach SrcA/SrcB in the same cycle (0 latency).

Outputs are valid during stall; forwarding keeps tracking changing M/W inputs while held.

Load-use stalls and branch resolution are outside this block; it only obeys StallE and FlushE.

Decomposition:
- Shared package: ALUControl encodings (ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLL=101, PASSB=111), forward-select constants (FWD_RF, FWD_WB, FWD_MEM), ResultSrc encodings, and a packed struct for the E-stage control bundle.
- One natural sub-module: forward_unit (combinational select generation, instantiated once per source operand).

Test Plan:
1. rst=1 for 2 cycles with nonzero D inputs -> all outputs 0, ValidE=0; first cycle after release captures D.
2. Back-to-back dependency: RdM=5, RegWriteM=1, ALUResultM=0x10, Rs1E=5 -> ForwardAE=10, SrcA=0x10. Additionally RdW=5, RegWriteW=1, ResultW=0x20 -> still 0x10 (MEM priority).
3. x0 guard: RdM=0, RegWriteM=1, Rs2E=0, ALUSrcE=0, RD2 registered as 0 -> ForwardBE=00, SrcB=0.
4. ALUSrcD=1, ImmExtD=0xFFFFFFFC, PCD=0x00000002 -> SrcB=0xFFFFFFFC, PCTargetE=0xFFFFFFFE. PCD=0x8, ImmExtD=0xFFFFFFF8 -> PCTargetE=0 (wrap).
5. StallE=1 for 3 cycles while D changes -> E registers hold. StallE=1 and FlushE=1 together -> bubble, all control 0.
6. RegWriteD=1, MemWriteD=1 with ValidD=0 -> RegWriteE=0, MemWriteE=0 next cycle.
